// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU opcodes, FSM state
// encoding and a small port-index helper.
package alu_share_ctrl_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned OPWIDTH_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd5;
  localparam logic [5:0] OP_SRL = 6'd6;
  localparam logic [5:0] OP_SRA = 6'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, contention goes to the
// port that did not win last time.
module rr_arb2 (
  input  logic [1:0] rq_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  always_comb begin
    any_valid = |rq_valid;
    grant     = 1'b0;
    case (rq_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU32 between two requesters: accept, execute with
// registered operands, then hold the registered result until consumed.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPWIDTH = 6,
  parameter int unsigned CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         rq_valid,
  output logic [1:0]         rq_ready,
  input  logic [OPWIDTH-1:0] rq_op0,
  input  logic [OPWIDTH-1:0] rq_op1,
  input  logic [WIDTH-1:0]   rq_in1_0,
  input  logic [WIDTH-1:0]   rq_in1_1,
  input  logic [WIDTH-1:0]   rq_in2_0,
  input  logic [WIDTH-1:0]   rq_in2_1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [OPWIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  input  logic [WIDTH-1:0]   alu_out,
  output logic [CNTW-1:0]    grant_cnt0,
  output logic [CNTW-1:0]    grant_cnt1
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_t state;
  logic   g_q;
  logic   last_grant;
  logic   arb_grant;
  logic   arb_any;

  rr_arb2 u_arb (
    .rq_valid  (rq_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .any_valid (arb_any)
  );

  // Ready is the only combinational output; it never depends on alu_out.
  always_comb begin
    rq_ready = '0;
    if (reset && (state == ST_IDLE) && arb_any) begin
      rq_ready = port_onehot(arb_grant);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      g_q        <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            alu_op     <= arb_grant ? rq_op1   : rq_op0;
            alu_in1    <= arb_grant ? rq_in1_1 : rq_in1_0;
            alu_in2    <= arb_grant ? rq_in2_1 : rq_in2_0;
            g_q        <= arb_grant;
            last_grant <= arb_grant;
            if (!arb_grant && (grant_cnt0 != '1)) begin
              grant_cnt0 <= grant_cnt0 + CNT_ONE;
            end
            if (arb_grant && (grant_cnt1 != '1)) begin
              grant_cnt1 <= grant_cnt1 + CNT_ONE;
            end
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_out;
          rsp_valid <= port_onehot(g_q);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[g_q]) begin
            rsp_valid <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural ALU32 and a transaction-level
// reference model (round-robin owner, saturating counters, result queue).
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  rq_valid = '0;
  logic [1:0]  rq_ready;
  logic [5:0]  rq_op0 = '0, rq_op1 = '0;
  logic [31:0] rq_in1_0 = '0, rq_in1_1 = '0, rq_in2_0 = '0, rq_in2_1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_data;
  logic [5:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  grant_cnt0, grant_cnt1;

  int   total = 0;
  int   bad   = 0;
  logic m_lg;
  int   m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_out = alu_ref(alu_op, alu_in1, alu_in2);

  alu_share_ctrl #(.WIDTH(32), .OPWIDTH(6), .CNTW(4)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_op0(rq_op0), .rq_op1(rq_op1),
    .rq_in1_0(rq_in1_0), .rq_in1_1(rq_in1_1), .rq_in2_0(rq_in2_0), .rq_in2_1(rq_in2_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic p);
    m_lg = p;
    if (p) m_cnt1 = (m_cnt1 < 15) ? m_cnt1 + 1 : 15;
    else   m_cnt0 = (m_cnt0 < 15) ? m_cnt0 + 1 : 15;
  endtask

  task automatic set_req(input logic p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p) begin rq_op1 = op; rq_in1_1 = a; rq_in2_1 = b; end
    else   begin rq_op0 = op; rq_in1_0 = a; rq_in2_0 = b; end
  endtask

  task automatic test_reset();
    reset = 1'b0; rq_valid = 2'b11; rsp_ready = 2'b00;
    tick(); tick();
    total++; if (rq_ready !== 2'b00) begin bad++; $display("FAIL reset_rq_ready got=%b want=00", rq_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    total++; if ({alu_op, alu_in1, alu_in2} !== 70'h0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_op, alu_in1, alu_in2); end
    total++; if ({grant_cnt0, grant_cnt1} !== 8'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h want=0", grant_cnt0, grant_cnt1); end
    m_lg = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    rq_valid = 2'b00; reset = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic        w;
    logic [31:0] res;
    set_req(1'b0, OP_SUB, 32'h10, 32'h01);
    set_req(1'b1, OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
    rq_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      w   = ~m_lg;
      res = w ? 32'hF0F00F0F : 32'h0000000F;
      total++; if (rq_ready !== port_onehot(w)) begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", k, rq_ready, port_onehot(w)); end
      tick(); model_accept(w);
      total++; if (rq_ready !== 2'b00) begin bad++; $display("FAIL cont_exec_ready%0d got=%b want=00", k, rq_ready); end
      tick();
      total++; if (rsp_valid !== port_onehot(w) || rsp_data !== res) begin bad++; $display("FAIL cont_rsp%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_data, port_onehot(w), res); end
      tick();
    end
    rq_valid = 2'b00;
    total++; if (grant_cnt0 !== 4'(m_cnt0) || grant_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL cont_cnt got=%h/%h want=%0d/%0d", grant_cnt0, grant_cnt1, m_cnt0, m_cnt1); end
    tick();
  endtask

  task automatic test_single_add();
    rsp_ready = 2'b11;
    set_req(1'b0, OP_ADD, 32'h5, 32'h3);
    rq_valid = 2'b01;
    #1;
    total++; if (rq_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b want=01", rq_ready); end
    tick(); model_accept(1'b0);
    total++; if (rq_ready !== 2'b00 || rsp_valid !== 2'b00) begin bad++; $display("FAIL add_exec got=%b/%b want=00/00", rq_ready, rsp_valid); end
    total++; if (alu_op !== OP_ADD || alu_in1 !== 32'h5 || alu_in2 !== 32'h3) begin bad++; $display("FAIL add_alu got=%h/%h/%h want=0/5/3", alu_op, alu_in1, alu_in2); end
    total++; if (grant_cnt0 !== 4'(m_cnt0)) begin bad++; $display("FAIL add_cnt got=%h want=%0d", grant_cnt0, m_cnt0); end
    rq_valid = 2'b00;
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h8) begin bad++; $display("FAIL add_rsp got=%b/%h want=01/00000008", rsp_valid, rsp_data); end
    tick();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL add_done got=%b want=00", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b00;
    set_req(1'b1, OP_SLL, 32'h1, 32'h4);
    rq_valid = 2'b10;
    #1;
    total++; if (rq_ready !== 2'b10) begin bad++; $display("FAIL bp_ready1 got=%b want=10", rq_ready); end
    tick(); model_accept(1'b1);
    set_req(1'b0, OP_OR, 32'hA0, 32'h05);
    rq_valid = 2'b01; rsp_ready = 2'b01;
    #1;
    total++; if (rq_ready !== 2'b00) begin bad++; $display("FAIL bp_exec_ready got=%b want=00", rq_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h10 || rq_ready !== 2'b00) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b want=10/00000010/00", k, rsp_valid, rsp_data, rq_ready); end
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    total++; if (rsp_valid !== 2'b10 || rq_ready !== 2'b00) begin bad++; $display("FAIL bp_release got=%b/%b want=10/00", rsp_valid, rq_ready); end
    tick();
    total++; if (rq_ready !== 2'b01 || rsp_valid !== 2'b00) begin bad++; $display("FAIL bp_next got=%b/%b want=01/00", rq_ready, rsp_valid); end
    tick(); model_accept(1'b0);
    rq_valid = 2'b00; rsp_ready = 2'b11;
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 32'hA5) begin bad++; $display("FAIL bp_rsp0 got=%b/%h want=01/000000a5", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_reset_exec();
    rsp_ready = 2'b11;
    set_req(1'b0, OP_AND, 32'hF0F0, 32'hFF00);
    set_req(1'b1, OP_ADD, 32'h1, 32'h1);
    rq_valid = 2'b01;
    #1;
    total++; if (rq_ready !== 2'b01) begin bad++; $display("FAIL rx_ready got=%b want=01", rq_ready); end
    tick(); model_accept(1'b0);
    reset = 1'b0; rq_valid = 2'b11;
    #1;
    total++; if (rq_ready !== 2'b00) begin bad++; $display("FAIL rx_ready_in_reset got=%b want=00", rq_ready); end
    tick();
    m_lg = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    reset = 1'b1;
    #1;
    total++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin bad++; $display("FAIL rx_no_rsp got=%b/%h want=00/0", rsp_valid, rsp_data); end
    total++; if ({alu_op, alu_in1, alu_in2} !== 70'h0 || {grant_cnt0, grant_cnt1} !== 8'h0) begin bad++; $display("FAIL rx_zero got=%h/%h/%h cnt=%h/%h want=0", alu_op, alu_in1, alu_in2, grant_cnt0, grant_cnt1); end
    total++; if (rq_ready !== 2'b01) begin bad++; $display("FAIL rx_first_win got=%b want=01", rq_ready); end
    tick(); model_accept(1'b0);
    rq_valid = 2'b00;
    #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rx_exec got=%b want=00", rsp_valid); end
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 32'hF000) begin bad++; $display("FAIL rx_rsp got=%b/%h want=01/0000f000", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_drop();
    int c0;
    c0 = m_cnt0;
    rsp_ready = 2'b00;
    set_req(1'b1, OP_SRL, 32'h80000000, 32'd31);
    rq_valid = 2'b10;
    #1;
    total++; if (rq_ready !== 2'b10) begin bad++; $display("FAIL drop_ready1 got=%b want=10", rq_ready); end
    tick(); model_accept(1'b1);
    set_req(1'b0, OP_SUB, 32'h55, 32'h11);
    rq_valid = 2'b01;
    #1;
    total++; if (rq_ready !== 2'b00) begin bad++; $display("FAIL drop_exec got=%b want=00", rq_ready); end
    tick();
    rq_valid = 2'b00; rsp_ready = 2'b10;
    #1;
    total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h1) begin bad++; $display("FAIL drop_rsp got=%b/%h want=10/00000001", rsp_valid, rsp_data); end
    tick();
    total++; if (rq_ready !== 2'b00 || rsp_valid !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b/%b want=00/00", rq_ready, rsp_valid); end
    total++; if (alu_op !== OP_SRL || alu_in1 !== 32'h80000000 || alu_in2 !== 32'd31) begin bad++; $display("FAIL drop_alu_hold got=%h/%h/%h want=6/80000000/1f", alu_op, alu_in1, alu_in2); end
    tick();
    total++; if (grant_cnt0 !== 4'(c0) || grant_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL drop_cnt got=%h/%h want=%0d/%0d", grant_cnt0, grant_cnt1, c0, m_cnt1); end
  endtask

  task automatic test_saturate();
    rsp_ready = 2'b11;
    for (int k = 0; k < 17; k++) begin
      set_req(1'b0, OP_ADD, $urandom, $urandom);
      rq_valid = 2'b01;
      #1;
      total++; if (rq_ready !== 2'b01) begin bad++; $display("FAIL sat_ready%0d got=%b want=01", k, rq_ready); end
      tick(); model_accept(1'b0);
      rq_valid = 2'b00;
      tick(); tick();
      total++; if (grant_cnt0 !== 4'(m_cnt0)) begin bad++; $display("FAIL sat_cnt%0d got=%h want=%0d", k, grant_cnt0, m_cnt0); end
    end
    total++; if (grant_cnt0 !== 4'hF || grant_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL sat_final got=%h/%h want=f/%0d", grant_cnt0, grant_cnt1, m_cnt1); end
  endtask

  task automatic test_random();
    logic        pv [2];
    logic [5:0]  pop [2];
    logic [31:0] pa [2], pb [2];
    logic        busy, bport, w;
    int          age, done;
    logic [31:0] bres;
    logic [1:0]  exp_rdy;
    busy = 1'b0; bport = 1'b0; w = 1'b0; age = 0; done = 0; bres = '0;
    for (int i = 0; i < 2; i++) begin pv[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0; end
    for (int cyc = 0; cyc < 1500 && done < 60; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1; pop[i] = 6'($urandom_range(0, 7)); pa[i] = $urandom; pb[i] = $urandom;
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      rq_valid = {pv[1], pv[0]};
      set_req(1'b0, pop[0], pa[0], pb[0]);
      set_req(1'b1, pop[1], pa[1], pb[1]);
      rsp_ready = 2'($urandom);
      #1;
      exp_rdy = 2'b00;
      if (!busy && (pv[0] || pv[1])) begin
        w = (pv[0] && pv[1]) ? ~m_lg : pv[1];
        exp_rdy = port_onehot(w);
      end
      total++; if (rq_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c%0d got=%b want=%b", cyc, rq_ready, exp_rdy); end
      if (busy && age > 0) begin
        total++; if (rsp_valid !== port_onehot(bport) || rsp_data !== bres) begin bad++; $display("FAIL rnd_rsp c%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_data, port_onehot(bport), bres); end
      end else begin
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rnd_rsp_idle c%0d got=%b want=00", cyc, rsp_valid); end
      end
      total++; if (grant_cnt0 !== 4'(m_cnt0) || grant_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL rnd_cnt c%0d got=%h/%h want=%0d/%0d", cyc, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1); end
      if (exp_rdy != 2'b00) begin
        busy = 1'b1; age = 0; bport = w; bres = alu_ref(pop[w], pa[w], pb[w]);
        model_accept(w);
        pv[w] = 1'b0;
      end else if (busy && age > 0 && rsp_ready[bport]) begin
        busy = 1'b0; done++;
      end else if (busy) begin
        age++;
      end
      tick();
    end
    rq_valid = 2'b00;
    total++; if (done < 60) begin bad++; $display("FAIL rnd_timeout got=%0d want=60 completed", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_add();
    test_backpressure();
    test_reset_exec();
    test_drop();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares one ALU32 instance between two requesters (execute stage = port 0, address/branch unit = port 1). Accepts one operation at a time via valid/ready, arbitrates round-robin, drives the ALU's in1/in2/op from registers, captures the combinational result and returns it to the winning requester with a held response handshake. Sits between the pipeline front end and the ALU datapath; the ALU itself remains purely combinational.

## Interface
- `WIDTH`, 32: data width, matches `` `width ``.
- `OPWIDTH`, 6: ALU opcode width, matches `` `OPWIDTH ``.
- `CNTW`, 16: width of per-port grant counters.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `rq_valid`  in  2  request valid, bit i = port i.
- `rq_ready`  out  2  request accepted this cycle, one-hot or zero.
- `rq_op0`, `rq_op1`  in  OPWIDTH  opcode per port.
- `rq_in1_0`, `rq_in1_1`, `rq_in2_0`, `rq_in2_1`  in  WIDTH  operands per port.
- `rsp_valid`  out  2  result valid for port i.
- `rsp_ready`  in  2  port i consumes result.
- `rsp_data`  out  WIDTH  result, shared bus, meaningful only when some `rsp_valid` bit is set.
- `alu_op`  out  OPWIDTH  to ALU32 `op`.
- `alu_in1`, `alu_in2`  out  WIDTH  to ALU32 `in1`/`in2`.
- `alu_out`  in  WIDTH  from ALU32 `out`.
- `grant_cnt0`, `grant_cnt1`  out  CNTW  accepted-request counters, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `rq_valid`, choose winner `g`; `rq_ready[g]=1` combinationally. On that edge, latch op/in1/in2 of `g` into `alu_op`/`alu_in1`/`alu_in2`, store `g`, set `last_grant=g`, increment `grant_cnt[g]` (saturate at all-ones), and go to EXEC.
- Arbitration: only one valid → it wins. Both valid → `!last_grant` wins. `last_grant` resets to 1, so port 0 wins the first contention.
- EXEC: ALU inputs are stable from registers; at the edge, capture `alu_out` into `rsp_data`, set `rsp_valid[g]`, and go to RESP.
- RESP: hold `rsp_valid[g]` and `rsp_data` until `rsp_ready[g]=1`. On that edge, clear `rsp_valid` and go to IDLE. `rsp_ready` of the non-granted port is ignored.
- `rq_ready` is 0 outside IDLE and whenever `reset=0`.
- Requesters hold valid and payload stable until ready. A requester may deassert valid before ready; the controller does not latch anything in that case.
- `alu_*` registers keep their last value after RESP; they do not return to zero.

## Timing
- Accept at edge N (valid&ready high in cycle N-1 → latched at N).
- EXEC occupies cycle N. Result registered at edge N+1; `rsp_valid` is high from cycle N+1.
- Minimum turnaround: 3 cycles per op when `rsp_ready` is tied high. The next request can be accepted in the cycle after the response is consumed.
- Reset (`reset=0` at an edge) from any state:
  - state → IDLE, `last_grant` → 1
  - `rsp_valid` → 0, `rsp_data` → 0
  - `alu_op`, `alu_in1`, `alu_in2` → 0
  - `grant_cnt0`, `grant_cnt1` → 0
  - An in-flight op is discarded with no response.
- Simultaneous events:
  - `rsp_ready` and a new `rq_valid` in RESP: only the response completes; the request is evaluated in the next IDLE cycle.
  - Counter saturation is independent per port.
- No combinational path from `alu_out` to any output except through the `rsp_data` register.

## Structure
- Shared package/`parameters.v`: `` `width ``, `` `OPWIDTH ``, ALU opcode constants (OP_ADD, OP_SUB, OP_SLL, …), FSM state encodings (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2).
- One natural sub-module: `rr_arb2`, the 2-way round-robin picker (inputs: `rq_valid`, `last_grant`; outputs: grant index and any-valid).
- ALU32 is instantiated by the parent, not inside this block. The bench instantiates ALU32 plus `alu_share_ctrl` together.

## Test plan
- Single ADD on port 0, in1=0x00000005, in2=0x00000003, `rsp_ready` tied 1 → `rq_ready[0]` for 1 cycle; `rsp_valid[0]` 2 cycles after accept with `rsp_data`=0x00000008; `grant_cnt0`=1.
- Both ports valid continuously: port 0 SUB 0x10-0x01, port 1 XOR 0xFFFF0000^0x0F0F0F0F → grants alternate 0,1,0,1. Results 0x0000000F and 0xF0F00F0F each go to the correct `rsp_valid` bit.
- Backpressure: port 1 SLL 0x1<<4 with `rsp_ready[1]=0` for 5 cycles → `rsp_valid[1]` and `rsp_data`=0x00000010 stay stable. No `rq_ready` while port 0 waits valid. Port 0 accepted the cycle after `rsp_ready[1]` rises.
- Reset pulse (`reset=0` for 1 cycle) during EXEC → no response issued. All outputs zero. The next port 0 request wins even if port 1 is valid (`last_grant`=1).
- Port 0 valid raised then dropped while port 1 is being served → no grant for port 0, `grant_cnt0` unchanged.
- Force `grant_cnt0` near all-ones (CNTW=4 build, 17 requests) → `grant_cnt0` saturates at 0xF.
